seg7_scan_driver: RTL



---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_scan_driver_if.sv | 23 ++
 rtl/seg7_hex_decode.sv | 15 +
 rtl/seg7_scan_driver.sv | 111 +++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment decode for the seven-segment display blocks.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active low.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    s = SEG_OFF;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle of seg7_scan_driver.
//   value/dp/digit_en/blink : content to show (driven by the master)
//   seg/dp_n/an/frame_start : pin-level outputs (driven by the scan driver, slave side)
interface seg7_scan_driver_if;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic [3:0]  blink;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_start;

  modport master (
    output value, dp, digit_en, blink,
    input  seg, dp_n, an, frame_start
  );

  modport slave (
    input  value, dp, digit_en, blink,
    output seg, dp_n, an, frame_start
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
//   nibble : 4-bit hex digit
//   seg    : {g,f,e,d,c,b,a}, active low
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.value/dp/digit_en/blink : display content, sampled once per frame
//   bus.seg/dp_n : shared active-low cathodes; bus.an : active-low anodes
//   bus.frame_start : one-cycle pulse at the start of each digit-0 slot
// Each slot lasts REFRESH_DIV cycles; the first BLANK_CYCLES keep all anodes
// off so the cathode bus can settle between digits. All pins are registered.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned BLINK_DIV    = 50000000
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned BLK_W = $clog2(BLINK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  logic [15:0] shadow_value_q, shadow_value_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [3:0]  shadow_en_q, shadow_en_d;
  logic [3:0]  shadow_blink_q, shadow_blink_d;

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_n_q, dp_n_d;
  logic       frame_start_q, frame_start_d;

  logic [3:0]  cur_nibble;
  logic [6:0]  dec_seg;
  logic [31:0] cnt_ext;
  logic        cnt_wrap, blink_wrap, frame_end, in_blank, vis, active;

  seg7_hex_decode u_dec (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    cnt_wrap   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    blink_wrap = (blink_cnt_q == BLK_W'(BLINK_DIV - 1));
    frame_end  = cnt_wrap && (idx_q == 2'd3);
    cnt_ext    = 32'(cnt_q);
    in_blank   = (cnt_ext < BLANK_CYCLES);
    cur_nibble = shadow_value_q[{idx_q, 2'b00} +: 4];

    cnt_d         = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d         = cnt_wrap ? idx_q + 2'd1 : idx_q;
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;

    // Capture on the last cycle of digit 3 so a whole frame uses one snapshot.
    shadow_value_d = frame_end ? bus.value    : shadow_value_q;
    shadow_dp_d    = frame_end ? bus.dp       : shadow_dp_q;
    shadow_en_d    = frame_end ? bus.digit_en : shadow_en_q;
    shadow_blink_d = frame_end ? bus.blink    : shadow_blink_q;

    vis    = shadow_en_q[idx_q] & ~(shadow_blink_q[idx_q] & blink_phase_q);
    active = vis && !in_blank;

    an_d          = active ? ~(4'b0001 << idx_q) : AN_OFF;
    seg_d         = active ? dec_seg : SEG_OFF;
    dp_n_d        = active ? ~shadow_dp_q[idx_q] : 1'b1;
    frame_start_d = (cnt_q == '0) && (idx_q == 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_en_q    <= '0;
      shadow_blink_q <= '0;
      an_q           <= AN_OFF;
      seg_q          <= SEG_OFF;
      dp_n_q         <= 1'b1;
      frame_start_q  <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_en_q    <= shadow_en_d;
      shadow_blink_q <= shadow_blink_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_n_q         <= dp_n_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.frame_start = frame_start_q;

endmodule
